ov7660_sccb_init: RTL and testbench
===================================

Name: ov7660_sccb_init

Overview:
- Upstream configuration stage for the OV7660 pixel-capture/TFT-write path.
- After reset, waits for camera power-up, then writes a fixed register table over SCCB (3-phase write: ID 0x42, sub-address, data).
- Asserts oDONE once the camera is configured for RGB565 output.
- oDONE gates the capture stage's reset/enable.

Parameters:
- CLK_DIV, 250: iCLK cycles per quarter-bit tick. One SCL period is 4*CLK_DIV cycles; 100 kHz at 100 MHz.
- PWR_WAIT, 24'd1_000_000: iCLK cycles between reset release and the first transaction.
- RST_WAIT, 24'd100_000: extra idle cycles after table entry 0. Entry 0 is COM7=0x80, the soft reset.
- GAP_WAIT, 16'd1000: idle cycles between consecutive transactions.
- NUM_REGS, 8'd64: maximum table entries scanned.

Ports:
- iCLK, in, 1: system clock.
- iRST, in, 1: asynchronous, active-low reset.
- iSTART, in, 1: re-run the table while in DONE. Level is sampled; one pulse is sufficient.
- oSCL, out, 1: SCCB clock. Push-pull; idle high.
- oSDA_OE, out, 1: 1 = drive SDA low, 0 = release. Open-drain emulation.
- iSDA, in, 1: SDA pin sense.
- oBUSY, out, 1: high from reset release until DONE, and during a re-run.
- oDONE, out, 1: table fully written. Held until iSTART or reset.
- oERR, out, 1: sticky NACK flag. Only meaningful with SCCB_ACK_CHECK_EN; otherwise tied 0.
- oIDX, out, 8: current table index, for debug.

Behaviour:
- Reset values:
  - oSCL=1, oSDA_OE=0 (SDA high), oBUSY=1, oDONE=0, oERR=0, oIDX=0.
  - State = PWRUP; all counters 0.
- Tick generator: a counter 0..CLK_DIV-1 issues one-cycle qtick at the wrap. It is free-running only outside PWRUP/GAP/DONE. It is cleared on every state entry.
- Table source: sub-module ov7660_reg_rom, combinational, index -> {addr[7:0], data[7:0]}. Entry 0xFFFF = end marker.
- States:
  - PWRUP: count PWR_WAIT cycles, then go to LOAD.
  - LOAD: latch the ROM word at oIDX.
    - If it is 0xFFFF or oIDX==NUM_REGS, go to DONE.
    - Otherwise build a 27-bit shift frame {0x42,Z,addr,Z,data,Z}, where Z = released, don't-care bit. Go to START.
  - START, 2 qticks: with SCL high, pull SDA low; then drive SCL low.
  - SHIFT: 27 bits, 4 qticks per bit.
    - q0: SCL low, update SDA from frame MSB.
    - q1: SCL high.
    - q2: SCL high; iSDA sampled on Z bits.
    - q3: SCL low.
    - Bit counter 0..26; after bit 26 go to STOP.
  - STOP, 3 qticks: SDA low, then SCL high, then SDA released.
  - GAP: wait GAP_WAIT cycles, or RST_WAIT+GAP_WAIT when oIDX==0. Then increment oIDX and go to LOAD.
  - DONE: oDONE=1, oBUSY=0, bus idle (SCL=1, SDA released). On iSTART=1: oIDX=0, oDONE=0, oBUSY=1, go to LOAD. PWR_WAIT is not repeated.
- SDA only changes while SCL is low, except inside START/STOP.
- iSTART is ignored outside DONE.
- Reset mid-transaction: bus returns to idle on the same edge. Any partial write is abandoned; the camera tolerates this because no STOP was issued.
- Latency: one transaction takes 2+108+3 = 113 qticks.

Optional Feature:
- SCCB_ACK_CHECK_EN defined:
  - iSDA sampled at q2 of each Z bit; a 1 means NACK.
  - On NACK: finish the current byte, issue STOP, wait GAP, retry the same index, up to 3 retries.
  - If the 4th attempt fails: set oERR=1, skip to the next index.
- SCCB_ACK_CHECK_EN undefined:
  - Z bits ignored, no retry logic, oERR constant 0.

Decomposition:
- Package ov7660_pkg holds:
  - SCCB_WR_ID=8'h42.
  - ROM_END=16'hFFFF.
  - State enum (PWRUP, LOAD, START, SHIFT, STOP, GAP, DONE).
  - Register-address localparams (COM7=8'h12, CLKRC=8'h11, COM15=8'h40).
- Sub-module ov7660_reg_rom holds the case-table ROM. Entries:
  - 0: 12_80
  - 1: 11_01
  - 2: 12_04 (RGB)
  - 3: 40_D0 (RGB565, full range)
  - ... the rest of the table.
  - last: FFFF

Test Plan:
- Reset, CLK_DIV=4, PWR_WAIT=100, bench ROM {12_80, 40_D0, FFFF} -> first SDA fall (SCL high) at cycle ~100; decoded bytes 42,12,80 then 42,40,D0; oDONE rises after the second STOP+GAP; oIDX=2.
- Measure the gap after entry 0 vs entry 1 -> RST_WAIT+GAP_WAIT vs GAP_WAIT cycles exactly.
- Bus monitor throughout -> SDA never toggles while SCL is high except at START/STOP; SCL period = 16 cycles.
- In DONE, pulse iSTART for 1 cycle -> oBUSY=1 next cycle, table replays without PWR_WAIT; iSTART pulsed during SHIFT has no effect.
- Assert iRST mid-SHIFT (bit 10) -> oSCL=1, oSDA_OE=0 immediately; after release, full PWR_WAIT and restart at index 0.
- With SCCB_ACK_CHECK_EN, slave NACKs the sub-address of entry 1 on every attempt -> 4 transactions for entry 1, oERR=1, oDONE still reached.

Source files
------------

// File: rtl/ov7660_pkg.sv
// Shared SCCB constants, OV7660 register addresses and the init-sequencer state type.
package ov7660_pkg;

  localparam logic [7:0]  SCCB_WR_ID = 8'h42;
  localparam logic [15:0] ROM_END    = 16'hFFFF;

  localparam logic [7:0] CLKRC  = 8'h11;
  localparam logic [7:0] COM7   = 8'h12;
  localparam logic [7:0] COM8   = 8'h13;
  localparam logic [7:0] TSLB   = 8'h3A;
  localparam logic [7:0] COM13  = 8'h3D;
  localparam logic [7:0] COM15  = 8'h40;
  localparam logic [7:0] RGB444 = 8'h8C;

  typedef enum logic [2:0] {
    PWRUP, LOAD, START, SHIFT, STOP, GAP, DONE
  } state_t;

  // 3-phase write frame; each trailing 1 is a released (ACK) bit slot.
  function automatic logic [26:0] sccb_frame(input logic [15:0] w);
    return {SCCB_WR_ID, 1'b1, w[15:8], 1'b1, w[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/ov7660_sccb_init_if.sv
// SCCB pin bundle: push-pull SCL, open-drain SDA emulated as a pull-down enable plus pin sense.
interface ov7660_sccb_init_if;
  logic oSCL;
  logic oSDA_OE;
  logic iSDA;

  modport master (output oSCL, output oSDA_OE, input iSDA);
  modport slave  (input oSCL, input oSDA_OE, output iSDA);
endinterface

// File: rtl/ov7660_reg_rom.sv
// OV7660 init table: index -> {sub-address, data}; ROM_END terminates the sequence.
module ov7660_reg_rom
  import ov7660_pkg::*;
(
  input  logic [7:0]  idx,
  output logic [15:0] word
);

  always_comb begin
    case (idx)
      8'd0:    word = {COM7,   8'h80};  // soft reset
      8'd1:    word = {CLKRC,  8'h01};
      8'd2:    word = {COM7,   8'h04};  // RGB output
      8'd3:    word = {COM15,  8'hD0};  // RGB565, full range
      8'd4:    word = {TSLB,   8'h04};
      8'd5:    word = {RGB444, 8'h00};
      8'd6:    word = {COM13,  8'h88};
      8'd7:    word = {COM8,   8'hE7};
      8'd8:    word = ROM_END;
      default: word = ROM_END;
    endcase
  end

endmodule

// File: rtl/ov7660_sccb_init.sv
// OV7660 power-up configuration: waits for the sensor, then writes the register ROM over SCCB.
// Optional SCCB_ACK_CHECK_EN: sample slave ACKs, retry a NACKed write up to 3 times, then flag oERR.
module ov7660_sccb_init
  import ov7660_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 250,
  parameter logic [23:0] PWR_WAIT = 24'd1_000_000,
  parameter logic [23:0] RST_WAIT = 24'd100_000,
  parameter logic [15:0] GAP_WAIT = 16'd1000,
  parameter logic [7:0]  NUM_REGS = 8'd64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  ov7660_sccb_init_if.master sccb,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oERR,
  output logic [7:0]         oIDX
);

  localparam logic [15:0] QMAX = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] qcnt;
  logic [23:0] wcnt;
  logic [1:0]  step;
  logic [4:0]  bitcnt;
  logic [26:0] frame;
  logic [15:0] rom_word;
  logic [23:0] gap_len;
  logic        qtick;
  logic        last_bit;

  ov7660_reg_rom u_rom (
    .idx  (oIDX),
    .word (rom_word)
  );

  assign qtick   = (qcnt == QMAX);
  assign gap_len = (oIDX == 8'd0) ? RST_WAIT + {8'd0, GAP_WAIT} : {8'd0, GAP_WAIT};

`ifdef SCCB_ACK_CHECK_EN
  logic       nack;
  logic [1:0] retry;
  logic       err;
  logic       z_bit;

  assign z_bit    = (bitcnt == 5'd8) || (bitcnt == 5'd17) || (bitcnt == 5'd26);
  // A NACK cuts the frame short right after the offending ACK slot.
  assign last_bit = (bitcnt == 5'd26) || nack;
  assign oERR     = err;
`else
  logic sda_unused;

  assign sda_unused = sccb.iSDA;
  assign last_bit   = (bitcnt == 5'd26);
  assign oERR       = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= PWRUP;
      qcnt         <= '0;
      wcnt         <= '0;
      step         <= '0;
      bitcnt       <= '0;
      frame        <= '0;
      sccb.oSCL    <= 1'b1;
      sccb.oSDA_OE <= 1'b0;
      oBUSY        <= 1'b1;
      oDONE        <= 1'b0;
      oIDX         <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack         <= 1'b0;
      retry        <= '0;
      err          <= 1'b0;
`endif
    end else begin
      qcnt <= qtick ? '0 : qcnt + 16'd1;
      case (state)
        PWRUP: begin
          qcnt <= '0;
          wcnt <= wcnt + 24'd1;
          if (wcnt + 24'd1 >= PWR_WAIT) begin
            wcnt  <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          qcnt   <= '0;
          step   <= '0;
          bitcnt <= '0;
`ifdef SCCB_ACK_CHECK_EN
          nack   <= 1'b0;
`endif
          if (rom_word == ROM_END || oIDX == NUM_REGS) begin
            state <= DONE;
            oBUSY <= 1'b0;
            oDONE <= 1'b1;
          end else begin
            frame <= sccb_frame(rom_word);
            state <= START;
          end
        end
        START: if (qtick) begin
          if (step == 2'd0) begin
            sccb.oSDA_OE <= 1'b1;
            step         <= 2'd1;
          end else begin
            sccb.oSCL <= 1'b0;
            step      <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: if (qtick) begin
          step <= step + 2'd1;
          case (step)
            2'd0: begin
              sccb.oSDA_OE <= ~frame[26];
              frame        <= {frame[25:0], 1'b0};
            end
            2'd1: sccb.oSCL <= 1'b1;
            2'd2: begin
`ifdef SCCB_ACK_CHECK_EN
              if (z_bit && sccb.iSDA) nack <= 1'b1;
`endif
            end
            default: begin
              sccb.oSCL <= 1'b0;
              bitcnt    <= bitcnt + 5'd1;
              if (last_bit) begin
                step  <= '0;
                state <= STOP;
              end
            end
          endcase
        end
        STOP: if (qtick) begin
          step <= step + 2'd1;
          case (step)
            2'd0:    sccb.oSDA_OE <= 1'b1;
            2'd1:    sccb.oSCL    <= 1'b1;
            default: begin
              sccb.oSDA_OE <= 1'b0;
              step         <= '0;
              wcnt         <= '0;
              state        <= GAP;
            end
          endcase
        end
        GAP: begin
          qcnt <= '0;
          wcnt <= wcnt + 24'd1;
          if (wcnt + 24'd1 >= gap_len) begin
            wcnt  <= '0;
            state <= LOAD;
`ifdef SCCB_ACK_CHECK_EN
            if (nack && retry != 2'd3) begin
              retry <= retry + 2'd1;
            end else begin
              if (nack) err <= 1'b1;
              retry <= '0;
              oIDX  <= oIDX + 8'd1;
            end
`else
            oIDX <= oIDX + 8'd1;
`endif
          end
        end
        DONE: begin
          qcnt <= '0;
          if (iSTART) begin
            oIDX  <= '0;
            oDONE <= 1'b0;
            oBUSY <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7660_sccb_init.sv
// Bench for ov7660_sccb_init: SCCB bus decoder feeding a frame scoreboard, plus timing and protocol checks.
module tb_ov7660_sccb_init;

  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned SCL_PERIOD  = 16;
  localparam int unsigned FIRST_START = 105;  // PWR_WAIT 100 + LOAD cycle + START qtick 4
  localparam int unsigned GAP0        = 75;   // RST_WAIT 50 + GAP_WAIT 20 + 1 + 4
  localparam int unsigned GAP1        = 25;   // GAP_WAIT 20 + 1 + 4
  localparam int unsigned RERUN_LAT   = 5;    // LOAD cycle + START qtick
  localparam int unsigned LIMIT       = 20000;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       iCLK   = 1'b0;
  logic       iRST   = 1'b0;
  logic       iSTART = 1'b0;
  logic       oBUSY, oDONE, oERR;
  logic [7:0] oIDX;
  logic       pull   = 1'b0;

  ov7660_sccb_init_if bus ();
  assign bus.iSDA = ~bus.oSDA_OE & ~pull;

  ov7660_sccb_init #(
    .CLK_DIV  (CLK_DIV),
    .PWR_WAIT (24'd100),
    .RST_WAIT (24'd50),
    .GAP_WAIT (16'd20),
    .NUM_REGS (8'd64)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (iSTART),
    .sccb   (bus),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE),
    .oERR   (oERR),
    .oIDX   (oIDX)
  );

  always #5 iCLK = ~iCLK;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [15:0] tbl[8] = '{16'h1280, 16'h1101, 16'h1204, 16'h40D0,
                          16'h3A04, 16'h8C00, 16'h3D88, 16'h13E7};

  int unsigned cyc;
  bit          in_tx;
  int          nrise, ntx, starts;
  logic [27:0] sh;
  int unsigned last_rise, stop_cyc, start_cyc;
  logic        p_scl, p_sda;
  bit          nack_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // Expected frame: {bit count, ID, sub-address, data}; a NACKed write stops after the sub-address.
  task automatic push_run(input bit nack1);
    for (int i = 0; i < 8; i++) begin
      if (nack1 && i == 1) repeat (4) sb.push_back({8'd18, 8'h42, tbl[i][15:8], 8'h00});
      else sb.push_back({8'd27, 8'h42, tbl[i]});
    end
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (!oDONE && n < LIMIT) begin
      @(negedge iCLK);
      n++;
    end
    chk(name, {31'd0, oDONE}, 32'd1);
  endtask

  always @(posedge iCLK or negedge iRST)
    if (!iRST) cyc <= 0;
    else       cyc <= cyc + 1;

  always @(negedge iCLK) begin
    logic        scl, sda;
    logic [31:0] got, want;
    if (!iRST) begin
      in_tx = 1'b0;
      nrise = 0;
      ntx   = 0;
      pull  = 1'b0;
      p_scl = 1'b1;
      p_sda = 1'b1;
    end else begin
      scl = bus.oSCL;
      sda = bus.iSDA;
      if (scl && p_scl && (sda != p_sda)) begin
        if (!sda && !in_tx) begin
          in_tx     = 1'b1;
          nrise     = 0;
          sh        = '0;
          start_cyc = cyc;
          starts++;
          if (ntx == 0)      chk("first_start_cycle", start_cyc, FIRST_START);
          else if (ntx == 1) chk("gap_after_entry0", cyc - stop_cyc, GAP0);
          else if (ntx == 2) chk("gap_after_entry1", cyc - stop_cyc, GAP1);
        end else if (sda && in_tx && (nrise == 28 || nrise == 19)) begin
          in_tx    = 1'b0;
          ntx++;
          stop_cyc = cyc;
          got = (nrise == 28) ? {8'd27, sh[27:20], sh[18:11], sh[9:2]}
                              : {8'd18, sh[18:11], sh[9:2], 8'h00};
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow got=%0h required=no_frame", got);
          end else begin
            want = sb.pop_front();
            chk("frame", got, want);
          end
        end else begin
          checks++;
          failures++;
          $display("FAIL sda_edge_scl_high got=sda%0b_at_rise%0d required=no_change", sda, nrise);
        end
      end
      if (scl && !p_scl && in_tx) begin
        if (nrise > 0) chk("scl_period", cyc - last_rise, SCL_PERIOD);
        last_rise = cyc;
        sh        = {sh[26:0], sda};
        nrise++;
      end
      // Slave pulls SDA low for each ACK slot, except a forced NACK of sub-address 0x11.
      if (!scl && p_scl)
        pull = in_tx && (nrise == 8 || nrise == 17 || nrise == 26) &&
               !(nack_mode && nrise == 17 && sh[7:0] == 8'h11);
      p_scl = scl;
      p_sda = sda;
    end
  end

  initial begin
    int unsigned s, n;
    int          n0;

    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_scl",    {31'd0, bus.oSCL},    32'd1);
    chk("rst_sda_oe", {31'd0, bus.oSDA_OE}, 32'd0);
    chk("rst_busy",   {31'd0, oBUSY},       32'd1);
    chk("rst_done",   {31'd0, oDONE},       32'd0);
    chk("rst_err",    {31'd0, oERR},        32'd0);
    chk("rst_idx",    {24'd0, oIDX},        32'd0);

    nack_mode = ACK_EN;
    push_run(nack_mode);
    @(posedge iCLK);
    #2 iRST = 1'b1;
    wait_done("run1_done");
    chk("run1_idx",   {24'd0, oIDX},  32'd8);
    chk("run1_busy",  {31'd0, oBUSY}, 32'd0);
    chk("run1_err",   {31'd0, oERR},  {31'd0, ACK_EN});
    chk("run1_sb",    sb.size(),      32'd0);
    nack_mode = 1'b0;

    push_run(1'b0);
    n0 = starts;
    @(negedge iCLK) iSTART = 1'b1;
    @(posedge iCLK);
    #1;
    s = cyc;
    chk("rerun_busy", {31'd0, oBUSY}, 32'd1);
    chk("rerun_done", {31'd0, oDONE}, 32'd0);
    iSTART = 1'b0;
    n = 0;
    while (starts == n0 && n < LIMIT) begin @(negedge iCLK); n++; end
    chk("rerun_latency", start_cyc - s, RERUN_LAT);
    n = 0;
    while (nrise < 5 && n < LIMIT) begin @(negedge iCLK); n++; end
    iSTART = 1'b1;
    @(negedge iCLK) iSTART = 1'b0;
    chk("shift_start_busy", {31'd0, oBUSY}, 32'd1);
    chk("shift_start_idx",  {24'd0, oIDX},  32'd0);
    wait_done("run2_done");
    chk("run2_idx", {24'd0, oIDX}, 32'd8);
    chk("run2_err", {31'd0, oERR}, {31'd0, ACK_EN});
    chk("run2_sb",  sb.size(),     32'd0);

    n0 = starts;
    @(negedge iCLK) iSTART = 1'b1;
    @(negedge iCLK) iSTART = 1'b0;
    n = 0;
    while ((starts == n0 || nrise < 10) && n < LIMIT) begin @(negedge iCLK); n++; end
    @(posedge iCLK);
    #2 iRST = 1'b0;
    #1;
    chk("midrst_scl",    {31'd0, bus.oSCL},    32'd1);
    chk("midrst_sda_oe", {31'd0, bus.oSDA_OE}, 32'd0);
    repeat (2) @(negedge iCLK);
    chk("midrst_idx",  {24'd0, oIDX},  32'd0);
    chk("midrst_busy", {31'd0, oBUSY}, 32'd1);
    chk("midrst_done", {31'd0, oDONE}, 32'd0);
    chk("midrst_err",  {31'd0, oERR},  32'd0);
    chk("midrst_sb",   sb.size(),      32'd0);
    push_run(1'b0);
    @(posedge iCLK);
    #2 iRST = 1'b1;
    wait_done("run3_done");
    chk("run3_idx", {24'd0, oIDX}, 32'd8);
    chk("run3_sb",  sb.size(),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
